// File: rtl/kappa3_pkg.sv
// Shared KAPPA3 definitions: one-hot phase encodings used by phasegen and the
// controller, plus the run-control state type.
package kappa3_pkg;

  localparam int unsigned PHASE_W = 4;

  localparam logic [PHASE_W-1:0] PH_NONE = 4'b0000;
  localparam logic [PHASE_W-1:0] PH_IF   = 4'b0001;
  localparam logic [PHASE_W-1:0] PH_DE   = 4'b0010;
  localparam logic [PHASE_W-1:0] PH_EX   = 4'b0100;
  localparam logic [PHASE_W-1:0] PH_WB   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DRAIN = 2'd3
  } run_state_e;

  // One-hot rotate: IF->DE->EX->WB->IF.
  function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] ph);
    next_phase = {ph[PHASE_W-2:0], ph[PHASE_W-1]};
  endfunction

endpackage

// File: rtl/phasegen_retire_counter.sv
// Retired-instruction counter: synchronous active-low clear, increment enable,
// silent wrap from all-ones to zero.
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/phasegen.sv
// KAPPA3 phase generator and run controller (IF/DE/EX/WB sequencing, run/stop/step).
// Optional PC breakpoint halt is compiled in when PHASEGEN_BREAKPOINT_EN is defined.
module phasegen
  import kappa3_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_req,
  input  logic             stop_req,
  input  logic             step_req,
  input  logic             mem_wait,
  input  logic [31:0]      pc,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  output logic [3:0]       cstate,
  output logic             running,
  output logic             halted_bp,
  output logic [CNT_W-1:0] inst_count
);

  run_state_e         state_q;
  logic [PHASE_W-1:0] phase_q;

  logic active_c;
  logic accept_c;
  logic wb_done_c;
  logic bp_hit_c;

  assign active_c  = (state_q != ST_IDLE);
  assign accept_c  = !active_c && !stop_req && (run_req || step_req);
  assign wb_done_c = active_c && (phase_q == PH_WB) && !mem_wait;

`ifdef PHASEGEN_BREAKPOINT_EN
  logic bp_skip_q;
  logic halted_q;

  // bp_skip lets a resume at the breakpoint PC execute that instruction once.
  assign bp_hit_c = active_c && (phase_q == PH_IF) && bp_en && (pc == bp_addr) && !bp_skip_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      bp_skip_q <= 1'b0;
      halted_q  <= 1'b0;
    end else if (accept_c) begin
      bp_skip_q <= 1'b1;
      halted_q  <= 1'b0;
    end else begin
      if (active_c && (phase_q == PH_IF)) bp_skip_q <= 1'b0;
      if (bp_hit_c)                       halted_q  <= 1'b1;
    end
  end

  assign halted_bp = halted_q;
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_en, bp_addr};
  assign bp_hit_c  = 1'b0;
  assign halted_bp = 1'b0;
`endif

  // Run-control FSM and phase register; a breakpoint hit overrides any request.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= PH_IF;
    end else if (bp_hit_c) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            state_q <= run_req ? ST_RUN : ST_STEP;
            phase_q <= PH_IF;
          end
        end
        ST_RUN: begin
          if (stop_req) state_q <= ST_DRAIN;
        end
        ST_STEP, ST_DRAIN: begin
          if (wb_done_c) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (active_c && !((phase_q == PH_WB) && mem_wait)) phase_q <= next_phase(phase_q);
    end
  end

  assign cstate  = (active_c && !bp_hit_c) ? phase_q : PH_NONE;
  assign running = active_c;

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire (
    .clk_i   (clock),
    .clr_n_i (reset),
    .inc_i   (wb_done_c),
    .count_o (inst_count)
  );

endmodule

// File: tb/tb_phasegen.sv
// Scoreboard bench for phasegen: the driver queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_phasegen;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run_req = 1'b0;
  logic        stop_req = 1'b0;
  logic        step_req = 1'b0;
  logic        mem_wait = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        bp_en = 1'b1;
  logic [31:0] bp_addr = 32'h0000_0010;
  logic [3:0]  cstate;
  logic        running;
  logic        halted_bp;
  logic [31:0] inst_count;

  localparam logic [3:0] N  = 4'b0000;
  localparam logic [3:0] IF = 4'b0001;
  localparam logic [3:0] DE = 4'b0010;
  localparam logic [3:0] EX = 4'b0100;
  localparam logic [3:0] WB = 4'b1000;

  typedef struct {
    logic [3:0]  cs;
    logic        run;
    logic        hb;
    logic [31:0] cnt;
    string       tag;
    int          idx;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc_idx = 0;
  string tag = "reset";

  phasegen #(.CNT_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .run_req    (run_req),
    .stop_req   (stop_req),
    .step_req   (step_req),
    .mem_wait   (mem_wait),
    .pc         (pc),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .cstate     (cstate),
    .running    (running),
    .halted_bp  (halted_bp),
    .inst_count (inst_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string what, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s cyc%0d got %h want %h", mon_e.tag, what, mon_e.idx, got, want);
    end
  endtask

  // Inputs for this cycle plus the outputs expected during this cycle.
  task automatic cyc(input logic rst, input logic run, input logic stop, input logic step,
                     input logic mw, input logic [31:0] pcv, input logic [3:0] ecs,
                     input logic erun, input logic ehb, input logic [31:0] ecnt);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; run_req = run; stop_req = stop; step_req = step; mem_wait = mw; pc = pcv;
    e.cs = ecs; e.run = erun; e.hb = ehb; e.cnt = ecnt; e.tag = tag; e.idx = cyc_idx;
    exp_q.push_back(e);
    cyc_idx++;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("cstate",     32'(cstate),    32'(mon_e.cs));
      check("running",    32'(running),   32'(mon_e.run));
      check("halted_bp",  32'(halted_bp), 32'(mon_e.hb));
      check("inst_count", inst_count,     mon_e.cnt);
    end
  end

  initial begin
    tag = "reset";
    cyc(0,0,0,0,0,0, N,0,0,0);
    cyc(0,0,0,0,0,0, N,0,0,0);

    tag = "run";
    cyc(1,1,0,0,0,0, N,0,0,0);
    for (int i = 0; i < 3; i++) begin
      cyc(1,0,0,0,0,0, IF,1,0,32'(i));
      cyc(1,0,0,0,0,0, DE,1,0,32'(i));
      cyc(1,0,0,0,0,0, EX,1,0,32'(i));
      cyc(1,0,0,0,0,0, WB,1,0,32'(i));
    end

    tag = "stop_ex";
    cyc(1,0,0,0,0,0, IF,1,0,3);
    cyc(1,0,0,0,0,0, DE,1,0,3);
    cyc(1,1,1,0,0,0, EX,1,0,3);
    cyc(1,0,0,0,0,0, WB,1,0,3);
    cyc(1,0,0,0,0,0, N,0,0,4);
    cyc(1,0,0,0,0,0, N,0,0,4);

    tag = "step_wait";
    cyc(1,0,0,1,0,0, N,0,0,4);
    cyc(1,0,0,0,0,0, IF,1,0,4);
    cyc(1,0,0,0,0,0, DE,1,0,4);
    cyc(1,0,0,0,0,0, EX,1,0,4);
    cyc(1,0,0,0,1,0, WB,1,0,4);
    cyc(1,0,0,0,1,0, WB,1,0,4);
    cyc(1,0,0,0,0,0, WB,1,0,4);
    cyc(1,0,0,0,0,0, N,0,0,5);

    tag = "stop_at_wb";
    cyc(1,1,0,0,0,0, N,0,0,5);
    cyc(1,0,0,0,0,0, IF,1,0,5);
    cyc(1,0,0,0,0,0, DE,1,0,5);
    cyc(1,0,0,0,0,0, EX,1,0,5);
    cyc(1,0,1,0,0,0, WB,1,0,5);
    cyc(1,0,0,0,0,0, IF,1,0,6);
    cyc(1,0,0,0,0,0, DE,1,0,6);
    cyc(1,0,0,0,0,0, EX,1,0,6);
    cyc(1,0,0,0,0,0, WB,1,0,6);
    cyc(1,0,0,0,0,0, N,0,0,7);

    tag = "idle_stop_prio";
    cyc(1,1,1,1,0,0, N,0,0,7);
    cyc(1,0,0,0,0,0, N,0,0,7);

    tag = "reset_mid";
    cyc(1,1,0,0,0,0, N,0,0,7);
    cyc(1,0,0,0,0,0, IF,1,0,7);
    cyc(0,0,0,0,0,0, DE,1,0,7);
    cyc(1,0,0,0,0,0, N,0,0,0);
    cyc(1,0,0,0,0,0, N,0,0,0);

    @(posedge clock);
    #1 force dut.u_retire.count_q = 32'hFFFF_FFFF;
    #1 release dut.u_retire.count_q;

    tag = "wrap";
    cyc(1,0,0,1,0,0, N,0,0,32'hFFFF_FFFF);
    cyc(1,0,0,0,0,0, IF,1,0,32'hFFFF_FFFF);
    cyc(1,0,0,0,0,0, DE,1,0,32'hFFFF_FFFF);
    cyc(1,0,0,0,0,0, EX,1,0,32'hFFFF_FFFF);
    cyc(1,0,0,0,0,0, WB,1,0,32'hFFFF_FFFF);
    cyc(1,0,0,0,0,0, N,0,0,0);

`ifdef PHASEGEN_BREAKPOINT_EN
    tag = "bp_hit";
    cyc(1,1,0,0,0,0, N,0,0,0);
    for (int k = 0; k < 3; k++) begin
      cyc(1,0,0,0,0,32'(4*k), IF,1,0,32'(k));
      cyc(1,0,0,0,0,32'(4*k), DE,1,0,32'(k));
      cyc(1,0,0,0,0,32'(4*k), EX,1,0,32'(k));
      cyc(1,0,0,0,0,32'(4*k), WB,1,0,32'(k));
    end
    cyc(1,0,1,0,0,32'h10, N,1,0,3);
    cyc(1,0,0,0,0,32'h10, N,0,1,3);

    tag = "bp_resume";
    cyc(1,1,0,0,0,32'h10, N,0,1,3);
    cyc(1,0,0,0,0,32'h10, IF,1,0,3);
    cyc(1,0,0,0,0,32'h10, DE,1,0,3);
    cyc(1,0,1,0,0,32'h10, EX,1,0,3);
    cyc(1,0,0,0,0,32'h10, WB,1,0,3);
    cyc(1,0,0,0,0,32'h10, N,0,0,4);
`else
    tag = "bp_disabled";
    cyc(1,1,0,0,0,32'h10, N,0,0,0);
    cyc(1,0,0,0,0,32'h10, IF,1,0,0);
    cyc(1,0,0,0,0,32'h10, DE,1,0,0);
    cyc(1,0,0,0,0,32'h10, EX,1,0,0);
    cyc(1,0,0,0,0,32'h10, WB,1,0,0);
    cyc(1,0,0,0,0,32'h10, IF,1,0,1);
    cyc(1,0,1,0,0,32'h10, DE,1,0,1);
    cyc(1,0,0,0,0,32'h10, EX,1,0,1);
    cyc(1,0,0,0,0,32'h10, WB,1,0,1);
    cyc(1,0,0,0,0,32'h10, N,0,0,2);
`endif

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clock);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phasegen.md
# phasegen

Phase generator and run controller for the KAPPA3 light core: produces the one-hot `cstate` (IF/DE/EX/WB) consumed by the controller, and sequences it under run, stop and single-step commands. It optionally halts on a PC breakpoint. It sits upstream of the controller and counts retired instructions for the debug front panel.

## Interface
Parameters:
- `CNT_W`, default 32, width of the retired-instruction counter.

Ports:
- `clock` input, 1: single clock; all state changes on the rising edge.
- `reset` input, 1: synchronous, active-low; sampled on `clock`.
- `run_req` input, 1: one-cycle pulse; start continuous execution.
- `stop_req` input, 1: one-cycle pulse; stop at the next instruction boundary.
- `step_req` input, 1: one-cycle pulse; execute exactly one instruction.
- `mem_wait` input, 1: high during WB extends WB by one cycle per cycle held.
- `pc` input, 32: current PC register value.
- `bp_en` input, 1: breakpoint enable.
- `bp_addr` input, 32: breakpoint address.
- `cstate` output, 4: one-hot phase (0001 IF, 0010 DE, 0100 EX, 1000 WB), or 0000 when not executing.
- `running` output, 1: high in RUN, STEP or DRAIN.
- `halted_bp` output, 1: sticky; last halt was caused by the breakpoint.
- `inst_count` output, CNT_W: number of completed WB phases.

## Operation
- Control FSM states:
  - IDLE: `cstate` = 0000.
  - RUN.
  - STEP.
  - DRAIN: stop pending, current instruction finishing.
- Phase register cycles IF→DE→EX→WB→IF, one phase per cycle, while not IDLE. WB holds while `mem_wait`=1.
- WB completes on a cycle with `cstate`=WB and `mem_wait`=0.
- IDLE transitions:
  - `stop_req`=1 → no-op (stop has priority over everything).
  - else `run_req` → RUN.
  - else `step_req` → STEP.
  - On acceptance: clear `halted_bp`, set `bp_skip`, set phase to IF.
- RUN transitions:
  - `stop_req` → DRAIN.
  - `run_req` and `step_req` are ignored.
- STEP and DRAIN: all requests ignored; on WB completion → IDLE.
- RUN on WB completion: stays in RUN; next phase is IF.
- Breakpoint, evaluated in any cycle where the phase register is IF and the FSM is not IDLE:
  - If `bp_en` && `pc`==`bp_addr` && !`bp_skip`: `cstate` is forced to 0000 that cycle, FSM → IDLE, `halted_bp` ← 1, phase stays IF.
  - `bp_skip` clears after the first IF issued, so resuming at a breakpoint PC executes that instruction.
- `inst_count` += 1 on each WB completion. It wraps all-ones → 0 without a flag.
- Reset values: FSM IDLE, phase IF, `cstate` 0000, `running` 0, `halted_bp` 0, `bp_skip` 0, `inst_count` 0.
- Reset asserted mid-instruction abandons the instruction immediately. No further phases are issued.

## Timing
- Request accepted at edge N → `cstate`=IF in cycle N+1.
- An instruction takes 4 cycles plus the number of `mem_wait` cycles in WB.
- In RUN, IF follows WB completion with zero idle cycles.
- STEP or DRAIN: `cstate`=0000 and `running`=0 in the cycle after WB completion.
- Breakpoint hit: `cstate` goes 0000 the same cycle (combinational from `pc`). `running`=0 from the next cycle.
- `stop_req` in the same cycle as a breakpoint hit: the breakpoint halt wins; `halted_bp`=1.
- `stop_req` in the WB-completion cycle of RUN: → DRAIN, which issues one more full instruction. This is the accepted behaviour.
- `cstate` is never non-one-hot other than 0000.

## Configuration
- `PHASEGEN_BREAKPOINT_EN` defined:
  - Breakpoint compare, `bp_skip` and the `halted_bp` logic are compiled in as described.
- Not defined:
  - `pc`, `bp_en` and `bp_addr` are ignored.
  - `halted_bp` is tied to 0.
  - IF is never suppressed.
  - Port list is unchanged.

## Structure
- Shared package `kappa3_pkg`:
  - Phase constants IF/DE/EX/WB (4-bit one-hot), also used by the controller.
  - FSM state typedef (IDLE/RUN/STEP/DRAIN).
- One sub-module: `retire_counter` (CNT_W-bit, sync active-low clear, increment enable, wrap).
- FSM, phase register and breakpoint compare stay in `phasegen`.

## Test plan
- Reset, then `run_req` pulse, `mem_wait`=0: `cstate` 0001,0010,0100,1000 repeating from cycle 1; `inst_count`=3 after 12 cycles.
- `step_req` from IDLE with `mem_wait` high for 2 WB cycles: IF,DE,EX,WB,WB,WB then 0000; `inst_count`=1; `running` low afterwards.
- RUN, `stop_req` during EX: WB completes, `cstate`=0000 next cycle; a `run_req` in the same cycle as `stop_req` is ignored.
- `PHASEGEN_BREAKPOINT_EN`, `bp_en`=1, `bp_addr`=0x00000010, `pc` steps 0,4,8,0x10: three instructions retire, `cstate`=0000 at `pc`=0x10, `halted_bp`=1; a `run_req` then executes 0x10 (`inst_count`=4) and clears `halted_bp`.
- Preload `inst_count`=0xFFFFFFFF (run 2^32 in sim via force) plus one WB completion → 0x00000000.
- `reset` low during DE of a running instruction: next cycle `cstate`=0000, `running`=0, `inst_count`=0.
